vga_sync_driver: RTL and testbench
==================================

# vga_sync_driver

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It drives the pixel coordinates consumed by `img_generator`, takes back its 3-bit colour, and produces registered, blanked RGB plus active-low sync pulses for the VGA DAC/pins. It is the display-side counterpart of the image generator and sits between it and the board's VGA connector.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- CLOCK_25  in  1  pixel clock; all logic on its rising edge
- RESET_N  in  1  asynchronous active-low reset
- color  in  3  pixel colour from image generator; bit2=R, bit1=G, bit0=B
- x  out  12  current horizontal counter, 0..H_TOTAL-1
- y  out  12  current vertical counter, 0..V_TOTAL-1
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE (decode of counters)
- VGA_HS  out  1  horizontal sync, active low, registered
- VGA_VS  out  1  vertical sync, active low, registered
- VGA_R / VGA_G / VGA_B  out  1 each  registered, blanked colour
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Counters are 12-bit, unsigned.
- h counter increments every cycle; at H_TOTAL-1 it wraps to 0 and v counter increments. v wraps from V_TOTAL-1 to 0 on the same h wrap.
- x/y are the counter registers directly; active is combinational decode. `color` is sampled in the same cycle as x/y (the generator is combinational).
- Output stage registers, per cycle: VGA_R/G/B = active ? color bits : 0; VGA_HS = ~(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]) = low for h 656..751; VGA_VS low for v 490..491; frame_start = (h==0 && v==0).
- Out-of-range colour outside active area (e.g. border at x==640) is forced to black.
- Reset values: h=v=0 so x=0, y=0, active=1; VGA_HS=1, VGA_VS=1, VGA_R/G/B=0, frame_start=0.
- Reset asserted mid-frame: all state returns to the values above immediately (asynchronously); timing restarts at (0,0) on release; no partial sync pulse is extended.

## Timing
- Latency: counters at (h,v) in cycle N -> corresponding RGB/HS/VS/frame_start visible in cycle N+1. All pins mutually aligned.
- First cycle after RESET_N rises: counters (0,0); frame_start high in the second cycle; then every 420000 cycles.
- HS low exactly 96 consecutive cycles per line; VS low exactly 2 full lines (1600 cycles) per frame, transitions aligned to h=0 of the counter.
- Line period 800 cycles; frame period 525 lines.

## Configuration
- VGA_TEST_PATTERN_EN defined: `color` input is ignored; active-area colour = (x / 80)[2:0], i.e. eight 80-pixel vertical bars 000..111 left to right; blanking, syncs and latency unchanged.
- Undefined: colour comes from `color` as specified above.

## Structure
- Package vga_pkg: the eight timing defaults, derived H_TOTAL/V_TOTAL, HS/VS start/end constants, 12-bit coordinate typedef.
- One sub-module natural: vga_axis_counter (count, enable in, wrap-at-TOTAL-1, terminal-count out), instanced for h (enable=1) and v (enable=h terminal count).

## Test plan
- Reset held then released with color=3'b111 -> during reset HS=VS=1, RGB=0, x=y=0; cycle after release RGB=111, frame_start high that cycle only.
- Run one line -> HS falls at output cycle for h=656, rises after exactly 96 cycles; x wraps 799->0 and y increments by 1 in the same cycle.
- Run one frame -> VS low for counter v=490..491 only (1600 cycles); y wraps 524->0; next frame_start exactly 420000 cycles after previous.
- color=3'b100 constant -> RGB=100 for h<640,v<480; RGB=000 for h=640..799 and v=480..524, including x==640.
- Assert RESET_N low at h=700,v=490 (inside HS and VS pulses) -> HS/VS return high, RGB 0 immediately; after release timing restarts at (0,0).
- VGA_TEST_PATTERN_EN defined, color=3'b000 -> output pixels x=0..79 RGB=000, x=80 RGB=001, x=560..639 RGB=111, blank outside active.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals/sync windows and the 12-bit coordinate type.
package vga_pkg;

    typedef logic [11:0] coord_t;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
    localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

    function automatic logic in_range(coord_t val, coord_t lo, coord_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 while enabled and flags the last position.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL = H_TOTAL_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output logic   tc
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    coord_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == LAST);

endmodule

// File: rtl/vga_sync_driver.sv
// VGA raster timing generator with one registered output stage (RGB, HS, VS, frame_start).
// Define VGA_TEST_PATTERN_EN to ignore `color` and emit eight 80-pixel vertical colour bars.
module vga_sync_driver
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic        CLOCK_25,
    input  logic        RESET_N,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        active,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_R,
    output logic        VGA_G,
    output logic        VGA_B,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t     h_count, v_count;
    logic       h_tc, v_tc;
    logic [2:0] pix_color;

    logic [2:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       fs_q, fs_d;
    logic       at_origin_q, at_origin_d;

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk   (CLOCK_25),
        .rst_n (RESET_N),
        .en    (1'b1),
        .count (h_count),
        .tc    (h_tc)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk   (CLOCK_25),
        .rst_n (RESET_N),
        .en    (h_tc),
        .count (v_count),
        .tc    (v_tc)
    );

    assign x      = h_count;
    assign y      = v_count;
    assign active = (h_count < coord_t'(H_ACTIVE)) && (v_count < coord_t'(V_ACTIVE));

`ifdef VGA_TEST_PATTERN_EN
    coord_t bar_idx;
    always_comb begin
        bar_idx   = h_count / coord_t'(80);
        pix_color = bar_idx[2:0];
    end
`else
    assign pix_color = color;
`endif

    // (0,0) is reachable only from reset or from the joint h/v wrap, so this flag tracks the origin.
    assign at_origin_d = h_tc && v_tc;

    always_comb begin
        rgb_d = active ? pix_color : 3'b000;
        hs_d  = ~in_range(h_count, HS_START, HS_END);
        vs_d  = ~in_range(v_count, VS_START, VS_END);
        fs_d  = at_origin_q;
    end

    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            rgb_q       <= 3'b000;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            fs_q        <= 1'b0;
            at_origin_q <= 1'b1;
        end else begin
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
            at_origin_q <= at_origin_d;
        end
    end

    assign VGA_R       = rgb_q[2];
    assign VGA_G       = rgb_q[1];
    assign VGA_B       = rgb_q[0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_driver.sv
// Bench for vga_sync_driver: full horizontal timing, shortened vertical timing so a frame is 8000 cycles.
module tb_vga_sync_driver;

    localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VA = 4, VF = 2, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    logic        CLOCK_25 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic [2:0]  color    = 3'b000;
    logic [11:0] x, y;
    logic        active, VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B, frame_start;

    always #20 CLOCK_25 = ~CLOCK_25;

    vga_sync_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .CLOCK_25    (CLOCK_25),
        .RESET_N     (RESET_N),
        .color       (color),
        .x           (x),
        .y           (y),
        .active      (active),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .frame_start (frame_start)
    );

    int         t;          // cycles since reset release = expected counter position
    logic [5:0] sb[$];      // expected {rgb, hs, vs, fs} for registered outputs
    int         n_checks = 0;
    int         n_pass   = 0;

    // got/exp layout: [30:28] rgb, [27] hs, [26] vs, [25] fs, [24] active, [23:12] x, [11:0] y
    function automatic logic [5:0] model_out(int tt, logic [2:0] c);
        int mh = tt % HT;
        int mv = (tt / HT) % VT;
        logic [2:0] pc;
        logic [2:0] rgb;
        logic hs, vs, fs;
`ifdef VGA_TEST_PATTERN_EN
        pc = 3'(mh / 80);
`else
        pc = c;
`endif
        rgb = (mh < HA && mv < VA) ? pc : 3'b000;
        hs  = !(mh >= HA + HF && mh < HA + HF + HSW);
        vs  = !(mv >= VA + VF && mv < VA + VF + VSW);
        fs  = (tt % FRAME) == 0;
        return {rgb, hs, vs, fs};
    endfunction

    function automatic logic [24:0] model_cnt(int tt);
        int mh = tt % HT;
        int mv = (tt / HT) % VT;
        return {(mh < HA && mv < VA), 12'(mh), 12'(mv)};
    endfunction

    function automatic logic [30:0] observe();
        return {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_start, active, x, y};
    endfunction

    task automatic step(output logic [30:0] got, output logic [30:0] exp);
        sb.push_back(model_out(t, color));
        @(posedge CLOCK_25);
        t++;
        @(negedge CLOCK_25);
        exp = {sb.pop_front(), model_cnt(t)};
        got = observe();
    endtask

    task automatic test_reset();
        logic [30:0] got, exp;
        RESET_N = 1'b0;
        color   = 3'b111;
        repeat (3) @(negedge CLOCK_25);
        n_checks++;
        got = observe();
        exp = {3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 12'd0, 12'd0};
        if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
        else n_pass++;

        RESET_N = 1'b1;
        t = 0;
        sb.delete();
        #1;
        n_checks++;
        got = observe();
        if (got !== exp) $display("FAIL release_hold got=%h exp=%h", got, exp);
        else n_pass++;

        step(got, exp);
        n_checks++;
        if (got !== exp) $display("FAIL first_cycle got=%h exp=%h", got, exp);
        else n_pass++;
        n_checks++;
        if ({got[30:28], got[25]} !== 4'b1111)
            $display("FAIL first_pixel rgb_fs got=%b exp=1111", {got[30:28], got[25]});
        else n_pass++;

        step(got, exp);
        n_checks++;
        if (got[25] !== 1'b0) $display("FAIL fs_one_cycle got=%b exp=0", got[25]);
        else n_pass++;
    endtask

    task automatic test_line();
        logic [30:0] got, exp;
        logic prev_hs = 1'b1;
        int fall_t = -1;
        int hs_low = 0;
        for (int i = 0; i < HT; i++) begin
            color = 3'($urandom);
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL line t=%0d got=%h exp=%h", t, got, exp);
            else n_pass++;
            if (prev_hs === 1'b1 && got[27] === 1'b0) fall_t = t;
            if (got[27] === 1'b0) hs_low++;
            prev_hs = got[27];
            if (t == HT) begin
                n_checks++;
                if (got[23:0] !== {12'd0, 12'd1})
                    $display("FAIL x_wrap_y_inc got=%h exp=000001", got[23:0]);
                else n_pass++;
            end
        end
        n_checks++;
        if (fall_t != HA + HF + 1) $display("FAIL hs_fall got=%0d exp=%0d", fall_t, HA + HF + 1);
        else n_pass++;
        n_checks++;
        if (hs_low != HSW) $display("FAIL hs_width got=%0d exp=%0d", hs_low, HSW);
        else n_pass++;
    endtask

    task automatic test_frame();
        logic [30:0] got, exp;
        int vs_low = 0;
        int fs_hits = 0;
        int fs_prev = -1;
        int fs_last = -1;
        color = 3'b100;
        while (t < 2 * FRAME + 1) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL frame t=%0d got=%h exp=%h", t, got, exp);
            else n_pass++;
            if (t <= FRAME && got[26] === 1'b0) vs_low++;
            if (got[25] === 1'b1) begin
                fs_hits++;
                fs_prev = fs_last;
                fs_last = t;
            end
            if ((t % HT) == HA + 1 && ((t / HT) % VT) < VA) begin
                n_checks++;
                if (got[30:28] !== 3'b000) $display("FAIL border_x640 t=%0d got=%b exp=000", t, got[30:28]);
                else n_pass++;
            end
        end
        n_checks++;
        if (vs_low != VSW * HT) $display("FAIL vs_width got=%0d exp=%0d", vs_low, VSW * HT);
        else n_pass++;
        n_checks++;
        if (fs_hits != 2 || fs_last - fs_prev != FRAME)
            $display("FAIL fs_period hits=%0d got=%0d exp=%0d", fs_hits, fs_last - fs_prev, FRAME);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [30:0] got, exp;
        int guard = 0;
        color = 3'b011;
        while (!((t % HT) == 700 && ((t / HT) % VT) == VA + VF) && guard < 2 * FRAME) begin
            step(got, exp);
            guard++;
            n_checks++;
            if (got !== exp) $display("FAIL pre_reset t=%0d got=%h exp=%h", t, got, exp);
            else n_pass++;
        end
        n_checks++;
        if (guard >= 2 * FRAME || got[27:26] !== 2'b00)
            $display("FAIL in_sync_pulses guard=%0d got=%b exp=00", guard, got[27:26]);
        else n_pass++;

        RESET_N = 1'b0;
        #1;
        n_checks++;
        got = observe();
        exp = {3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 12'd0, 12'd0};
        if (got !== exp) $display("FAIL async_reset got=%h exp=%h", got, exp);
        else n_pass++;

        repeat (2) @(negedge CLOCK_25);
        RESET_N = 1'b1;
        t = 0;
        sb.delete();
        for (int i = 0; i < 900; i++) begin
            step(got, exp);
            n_checks++;
            if (got !== exp) $display("FAIL restart t=%0d got=%h exp=%h", t, got, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
